// File: rtl/cpu_pkg.sv
// Shared CPU definitions: opcode values, instruction field layout, PC width
// and the fetch-unit state encoding.
package cpu_pkg;

    localparam int WORD_W = 16;
    localparam int PC_W   = 8;
    localparam int OPC_HI = 15;
    localparam int OPC_LO = 12;

    localparam logic [3:0] OP_LOAD   = 4'b0000;
    localparam logic [3:0] OP_MOVE   = 4'b0001;
    localparam logic [3:0] OP_ADD    = 4'b0010;
    localparam logic [3:0] OP_LDPC   = 4'b0101;
    localparam logic [3:0] OP_BRANCH = 4'b0110;
    localparam logic [3:0] OP_HALT   = 4'b1111;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_FETCH   = 3'd1,
        ST_CAPTURE = 3'd2,
        ST_ISSUE   = 3'd3,
        ST_EXEC    = 3'd4,
        ST_HALT    = 3'd5
    } fetch_state_t;

    function automatic logic is_halt_op(input logic [3:0] opcode);
        return (opcode == OP_HALT);
    endfunction

endpackage

// File: rtl/fetch_pc.sv
// Program counter: branch load has priority over increment; the increment
// wraps naturally modulo 2**PC_W.
module fetch_pc
    import cpu_pkg::*;
(
    input  logic            clk,
    input  logic            rst,
    input  logic            inc,
    input  logic            load,
    input  logic [PC_W-1:0] load_val,
    output logic [PC_W-1:0] pc
);

    logic [PC_W-1:0] pc_r;

    // PC register update
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pc_r <= {PC_W{1'b0}};
        end else if (load) begin
            pc_r <= load_val;
        end else if (inc) begin
            pc_r <= pc_r + {{(PC_W-1){1'b0}}, 1'b1};
        end else begin
            pc_r <= pc_r;
        end
    end

    assign pc = pc_r;

endmodule

// File: rtl/instr_fetch_unit.sv
// Instruction fetch sequencer: fetches from instruction memory, hands each
// instruction to the control unit and waits for it to complete.
module instr_fetch_unit
    import cpu_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              run,
    output logic [PC_W-1:0]   imem_addr,
    input  logic [WORD_W-1:0] imem_data,
    output logic [WORD_W-1:0] instr,
    output logic              new_instr,
    input  logic              cu_done,
    input  logic              pc_load,
    input  logic [WORD_W-1:0] pc_in,
    output logic [WORD_W-1:0] pc_out,
    output logic              halted
);

    fetch_state_t      state_r;
    logic [WORD_W-1:0] instr_r;
    logic              new_instr_r;
    logic              halted_r;
    logic [PC_W-1:0]   pc_s;
    logic              pc_inc_s;
    logic              pc_load_s;
    logic              unused_pc_hi_s;

    // Upper bus bits carry no address information
    assign unused_pc_hi_s = ^pc_in[WORD_W-1:PC_W];

    // PC control: advance after capture, accept branches only while executing
    always_comb begin
        pc_inc_s  = 1'b0;
        pc_load_s = 1'b0;
        if (state_r == ST_CAPTURE) begin
            pc_inc_s = 1'b1;
        end else begin
            pc_inc_s = 1'b0;
        end
        if ((state_r == ST_EXEC) && pc_load) begin
            pc_load_s = 1'b1;
        end else begin
            pc_load_s = 1'b0;
        end
    end

    fetch_pc u_fetch_pc (
        .clk      (clk),
        .rst      (rst),
        .inc      (pc_inc_s),
        .load     (pc_load_s),
        .load_val (pc_in[PC_W-1:0]),
        .pc       (pc_s)
    );

    // Fetch sequencer with registered instruction, issue pulse and halt flag
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r     <= ST_IDLE;
            instr_r     <= {WORD_W{1'b0}};
            new_instr_r <= 1'b0;
            halted_r    <= 1'b0;
        end else begin
            new_instr_r <= 1'b0;
            case (state_r)
                ST_IDLE: begin
                    if (run) begin
                        state_r <= ST_FETCH;
                    end else begin
                        state_r <= ST_IDLE;
                    end
                end
                ST_FETCH: begin
                    state_r <= ST_CAPTURE;
                end
                ST_CAPTURE: begin
                    instr_r <= imem_data;
                    if (is_halt_op(imem_data[OPC_HI:OPC_LO])) begin
                        state_r  <= ST_HALT;
                        halted_r <= 1'b1;
                    end else begin
                        state_r     <= ST_ISSUE;
                        new_instr_r <= 1'b1;
                    end
                end
                ST_ISSUE: begin
                    state_r <= ST_EXEC;
                end
                ST_EXEC: begin
                    if (cu_done && run) begin
                        state_r <= ST_FETCH;
                    end else if (cu_done) begin
                        state_r <= ST_IDLE;
                    end else begin
                        state_r <= ST_EXEC;
                    end
                end
                ST_HALT: begin
                    state_r  <= ST_HALT;
                    halted_r <= 1'b1;
                end
                default: begin
                    state_r  <= ST_IDLE;
                    halted_r <= 1'b0;
                end
            endcase
        end
    end

    assign imem_addr = pc_s;
    assign pc_out    = {{(WORD_W-PC_W){1'b0}}, pc_s};
    assign instr     = instr_r;
    assign new_instr = new_instr_r;
    assign halted    = halted_r;

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Directed bench for instr_fetch_unit with a synchronous-read instruction memory.
module tb_instr_fetch_unit;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        run = 1'b0;
    logic [7:0]  imem_addr;
    logic [15:0] imem_data = 16'h0000;
    logic [15:0] instr;
    logic        new_instr;
    logic        cu_done = 1'b0;
    logic        pc_load = 1'b0;
    logic [15:0] pc_in = 16'h0000;
    logic [15:0] pc_out;
    logic        halted;

    logic [15:0] mem [256];
    int compared   = 0;
    int mismatched = 0;
    int pulses;
    int lost_halt;

    always #5 clk = ~clk;

    always @(posedge clk) imem_data <= mem[imem_addr];

    instr_fetch_unit dut (
        .clk       (clk),
        .rst       (rst),
        .run       (run),
        .imem_addr (imem_addr),
        .imem_data (imem_data),
        .instr     (instr),
        .new_instr (new_instr),
        .cu_done   (cu_done),
        .pc_load   (pc_load),
        .pc_in     (pc_in),
        .pc_out    (pc_out),
        .halted    (halted)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_instr"}, instr, 16'h0000);
        check({tag, "_new_instr"}, {15'd0, new_instr}, 16'h0000);
        check({tag, "_halted"}, {15'd0, halted}, 16'h0000);
        check({tag, "_imem_addr"}, {8'd0, imem_addr}, 16'h0000);
        check({tag, "_pc_out"}, pc_out, 16'h0000);
    endtask

    // From EXEC: pulse cu_done with run=1, then expect the next issue 3 cycles later
    task automatic complete_and_issue(input string tag, input logic [15:0] exp_instr,
                                      input logic [7:0] exp_addr);
        cu_done = 1'b1;
        tick();
        cu_done = 1'b0;
        pc_load = 1'b0;
        check({tag, "_fetch_ni"}, {15'd0, new_instr}, 16'h0000);
        tick();
        tick();
        check({tag, "_ni"}, {15'd0, new_instr}, 16'h0001);
        check({tag, "_instr"}, instr, exp_instr);
        check({tag, "_addr"}, {8'd0, imem_addr}, {8'd0, exp_addr});
        tick();
        check({tag, "_ni_width"}, {15'd0, new_instr}, 16'h0000);
    endtask

    initial begin
        for (int i = 0; i < 256; i++) mem[i] = 16'h0000;
        mem[0] = 16'h02FF;

        // Reset state, then a single instruction with run dropped during it
        tick();
        tick();
        check_reset_outputs("reset");
        rst = 1'b0;
        run = 1'b1;
        tick();
        check("s1_fetch_ni", {15'd0, new_instr}, 16'h0000);
        check("s1_fetch_addr", {8'd0, imem_addr}, 16'h0000);
        tick();
        check("s1_capt_ni", {15'd0, new_instr}, 16'h0000);
        tick();
        check("s1_issue_ni", {15'd0, new_instr}, 16'h0001);
        check("s1_issue_instr", instr, 16'h02FF);
        check("s1_issue_addr", {8'd0, imem_addr}, 16'h0001);
        run = 1'b0;
        tick();
        check("s1_exec_ni", {15'd0, new_instr}, 16'h0000);
        check("s1_exec_instr", instr, 16'h02FF);
        cu_done = 1'b1;
        tick();
        cu_done = 1'b0;
        pulses = 0;
        for (int i = 0; i < 6; i++) begin
            tick();
            if (new_instr) pulses++;
        end
        check("s1_idle_no_issue", pulses[15:0], 16'h0000);
        check("s1_idle_addr", {8'd0, imem_addr}, 16'h0001);

        // Ordered issue, branch, wrap and halt program
        mem[0]     = 16'h1610;
        mem[1]     = 16'h2260;
        mem[2]     = 16'hF000;
        mem[8'h40] = 16'h5123;
        mem[8'hFF] = 16'h0000;
        rst = 1'b1;
        tick();
        rst = 1'b0;
        run = 1'b1;
        tick();
        tick();
        tick();
        check("s2_i0_ni", {15'd0, new_instr}, 16'h0001);
        check("s2_i0_instr", instr, 16'h1610);
        check("s2_i0_pc", pc_out, 16'h0001);
        tick();
        check("s2_i0_width", {15'd0, new_instr}, 16'h0000);
        tick();
        cu_done = 1'b1;
        tick();
        // FETCH: cu_done and pc_load here must have no effect
        pc_load = 1'b1;
        pc_in   = 16'h0077;
        check("s2_i1_fetch_ni", {15'd0, new_instr}, 16'h0000);
        tick();
        cu_done = 1'b0;
        pc_load = 1'b0;
        tick();
        check("s2_i1_ni", {15'd0, new_instr}, 16'h0001);
        check("s2_i1_instr", instr, 16'h2260);
        check("s2_i1_pc", pc_out, 16'h0002);
        tick();
        check("s2_i1_width", {15'd0, new_instr}, 16'h0000);

        // Branch with simultaneous cu_done
        pc_load = 1'b1;
        pc_in   = 16'hAB40;
        cu_done = 1'b1;
        tick();
        pc_load = 1'b0;
        cu_done = 1'b0;
        check("br_addr", {8'd0, imem_addr}, 16'h0040);
        check("br_pc_out", pc_out, 16'h0040);
        tick();
        tick();
        check("br_ni", {15'd0, new_instr}, 16'h0001);
        check("br_instr", instr, 16'h5123);
        check("br_next_addr", {8'd0, imem_addr}, 16'h0041);
        tick();

        // Branch to 0xFF and wrap back to 0
        pc_load = 1'b1;
        pc_in   = 16'h00FF;
        cu_done = 1'b1;
        tick();
        pc_load = 1'b0;
        cu_done = 1'b0;
        check("wrap_fetch_addr", {8'd0, imem_addr}, 16'h00FF);
        tick();
        tick();
        check("wrap_ni", {15'd0, new_instr}, 16'h0001);
        check("wrap_instr", instr, 16'h0000);
        check("wrap_addr", {8'd0, imem_addr}, 16'h0000);
        tick();
        complete_and_issue("wrap_refetch", 16'h1610, 8'h01);
        complete_and_issue("pre_halt", 16'h2260, 8'h02);

        // Halt word
        cu_done = 1'b1;
        tick();
        cu_done = 1'b0;
        tick();
        check("halt_capt_halted", {15'd0, halted}, 16'h0000);
        tick();
        check("halt_halted", {15'd0, halted}, 16'h0001);
        check("halt_ni", {15'd0, new_instr}, 16'h0000);
        check("halt_instr", instr, 16'hF000);
        check("halt_addr", {8'd0, imem_addr}, 16'h0003);
        pulses    = 0;
        lost_halt = 0;
        for (int i = 0; i < 20; i++) begin
            run     = i[0];
            cu_done = i[1];
            pc_load = i[2];
            pc_in   = 16'h0011;
            tick();
            if (new_instr) pulses++;
            if (!halted) lost_halt++;
        end
        check("halt_no_issue", pulses[15:0], 16'h0000);
        check("halt_stays", lost_halt[15:0], 16'h0000);
        check("halt_instr_hold", instr, 16'hF000);
        check("halt_addr_hold", {8'd0, imem_addr}, 16'h0003);
        pc_load = 1'b0;
        cu_done = 1'b0;
        run     = 1'b0;

        // Asynchronous reset out of HALT
        #2;
        rst = 1'b1;
        #1;
        check_reset_outputs("halt_rst");
        tick();
        rst = 1'b0;
        run = 1'b1;
        tick();
        tick();
        tick();
        check("post_rst_ni", {15'd0, new_instr}, 16'h0001);
        check("post_rst_instr", instr, 16'h1610);
        check("post_rst_addr", {8'd0, imem_addr}, 16'h0001);

        // Asynchronous reset in EXEC
        tick();
        #2;
        rst = 1'b1;
        #1;
        check_reset_outputs("exec_rst");

        // run dropped mid-EXEC finishes the instruction then idles
        tick();
        rst = 1'b0;
        run = 1'b1;
        tick();
        tick();
        tick();
        check("s3_ni", {15'd0, new_instr}, 16'h0001);
        tick();
        run = 1'b0;
        tick();
        check("s3_exec_hold", instr, 16'h1610);
        cu_done = 1'b1;
        tick();
        cu_done = 1'b0;
        pulses = 0;
        for (int i = 0; i < 6; i++) begin
            tick();
            if (new_instr) pulses++;
        end
        check("s3_idle_no_issue", pulses[15:0], 16'h0000);
        check("s3_idle_addr", {8'd0, imem_addr}, 16'h0001);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule

// File: doc/instr_fetch_unit.md
INSTR_FETCH_UNIT -- requirements
Module: instr_fetch_unit

Interface
REQ-001 SHALL have port clk, input, 1 bit: single system clock, all state updates on rising edge.
REQ-002 SHALL have port rst, input, 1 bit: asynchronous, active-high reset.
REQ-003 SHALL have port run, input, 1 bit: fetch enable; sampled in IDLE and at instruction completion.
REQ-004 SHALL have port imem_addr, output, 8 bits: instruction memory address, always equal to PC.
REQ-005 SHALL have port imem_data, input, 16 bits: instruction memory read data, valid one cycle after imem_addr.
REQ-006 SHALL have port instr, output, 16 bits: current instruction to control unit; bits [15:12] are the opcode.
REQ-007 SHALL have port new_instr, output, 1 bit: one-cycle pulse telling the control unit to start a new instruction.
REQ-008 SHALL have port cu_done, input, 1 bit: control unit has finished the current instruction.
REQ-009 SHALL have port pc_load, input, 1 bit: branch request; load PC from pc_in.
REQ-010 SHALL have port pc_in, input, 16 bits: branch target from the bus; bits [7:0] used, [15:8] ignored.
REQ-011 SHALL have port pc_out, output, 16 bits: PC zero-extended for bus drive (ldpc).
REQ-012 SHALL have port halted, output, 1 bit: high while in HALT.

Function
REQ-013 SHALL implement states IDLE, FETCH, CAPTURE, ISSUE, EXEC, HALT.
REQ-014 IDLE SHALL move to FETCH when run=1 and SHALL stay in IDLE otherwise.
REQ-015 FETCH SHALL present imem_addr=PC and SHALL always move to CAPTURE.
REQ-016 CAPTURE SHALL latch imem_data into instr, increment PC by 1 mod 256 (255->0), then go to HALT if opcode=1111, else to ISSUE.
REQ-017 ISSUE SHALL assert new_instr=1 for exactly one cycle and SHALL then go to EXEC.
REQ-018 EXEC SHALL hold instr stable until cu_done=1, then go to FETCH if run=1, else IDLE.
REQ-019 Latency SHALL be 3 cycles from run sampled high in IDLE to new_instr high, and 3 cycles from cu_done to the next new_instr.
REQ-020 pc_load=1 in EXEC SHALL set PC to pc_in[7:0] on that edge; pc_load in any other state SHALL be ignored.
REQ-021 pc_load and cu_done in the same EXEC cycle: the load SHALL take effect and the next FETCH SHALL use the loaded PC.
REQ-022 cu_done outside EXEC SHALL be ignored.
REQ-023 HALT SHALL be exited only by rst; new_instr SHALL stay 0; instr SHALL hold the halt word; halted=1.
REQ-024 run deasserted during FETCH/CAPTURE/ISSUE/EXEC SHALL NOT abort; the in-flight instruction completes, then IDLE.
REQ-025 instr SHALL change only in CAPTURE; new_instr SHALL be 1 only in ISSUE.

Reset
REQ-026 rst SHALL immediately force state=IDLE, PC=0, instr=0, new_instr=0, halted=0, pc_out=0, imem_addr=0, regardless of clock and mid-operation state.
REQ-027 After rst deasserts, the first fetch SHALL be from address 0.

Structure
REQ-028 Opcode constants (LOAD=0000, MOVE=0001, ADD=0010, LDPC=0101, BRANCH=0110, HALT=1111), opcode field position [15:12], PC width 8 and the state encoding SHALL reside in shared package cpu_pkg.
REQ-029 The PC register with increment/load/wrap SHALL be a sub-module named fetch_pc; the FSM stays in instr_fetch_unit.

Verification
REQ-030 Reset, run=1, mem[0]=0x02FF: new_instr pulse at cycle 3 with instr=0x02FF; imem_addr=1 after CAPTURE.
REQ-031 mem[0]=0x1610, mem[1]=0x2260, cu_done pulsed 2 cycles after each new_instr: instructions issued in order; PC 0->1->2; each new_instr exactly 1 cycle wide.
REQ-032 Branch: in EXEC, pc_load=1, pc_in=0xAB40, cu_done=1 same cycle: next imem_addr=0x40; pc_out=0x0040.
REQ-033 PC=0xFF with mem[255]=0x0000: after CAPTURE PC=0x00; next fetch from address 0.
REQ-034 mem[2]=0xF000: after CAPTURE halted=1; no further new_instr for 20 cycles despite cu_done/run toggling; rst returns to IDLE with PC=0.
REQ-035 rst asserted during EXEC: outputs reach reset values before the next clock edge; run=0 mid-EXEC ends in IDLE after cu_done.
